// File: rtl/qupls_mc_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer.
//   mc_address_t      microcode ROM address
//   ex_instruction_t  parent instruction handed over by decode/rename
//   mc_word_t         layout of one microcode ROM word (end bit at the top)
//   mc_seq_state_t    sequencer FSM states
package qupls_mc_sequencer_pkg;

  localparam int MC_AW      = 12;
  localparam int MC_UOPW    = 32;
  localparam int MC_LCW     = 5;
  localparam int MC_MAXSTEP = 64;

  typedef logic [MC_AW-1:0] mc_address_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [13:0] imm;
  } ex_instruction_t;

  typedef struct packed {
    logic               last;
    logic               loop;
    logic               jmp;
    mc_address_t        nxt;
    logic [MC_UOPW-1:0] uop;
  } mc_word_t;

  typedef enum logic [0:0] {
    MC_IDLE = 1'b0,
    MC_ISS  = 1'b1
  } mc_seq_state_t;

endpackage

// File: rtl/qupls_mc_nextaddr.sv
// Next microcode address selection (purely combinational).
//   cur     current micro-word address
//   nxt     micro-word target field
//   jmp     unconditional jump flag
//   loop    counted-loop flag (branch to nxt while lc != 0)
//   lc      current loop count
//   addr    selected next address
//   lc_nxt  loop count after this step
//   wrap    sequential increment overflowed the address space
module qupls_mc_nextaddr #(
  parameter int AW  = 12,
  parameter int LCW = 5
) (
  input  logic [AW-1:0]  cur,
  input  logic [AW-1:0]  nxt,
  input  logic           jmp,
  input  logic           loop,
  input  logic [LCW-1:0] lc,
  output logic [AW-1:0]  addr,
  output logic [LCW-1:0] lc_nxt,
  output logic           wrap
);

  logic [AW:0] inc;

  assign inc = {1'b0, cur} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    addr   = inc[AW-1:0];
    lc_nxt = lc;
    wrap   = 1'b0;
    if (loop && (lc != '0)) begin
      addr   = nxt;
      lc_nxt = lc - {{(LCW-1){1'b0}}, 1'b1};
    end else if (jmp && !loop) begin
      addr = nxt;
    end else begin
      // an exhausted loop falls through sequentially even if jmp is also set
      wrap = inc[AW];
    end
  end

endmodule

// File: rtl/qupls_mc_sequencer.sv
// Microcode sequencer: accepts a microcoded instruction plus its entry
// address, walks the microcode ROM and emits one micro-op per cycle.
//   clk, rst_n            clock, async active-low reset
//   ins_valid/ins_ready   instruction handshake; ins, mip, lpcnt captured
//   flush                 abandon current sequence, back to idle
//   rom_en/rom_addr       ROM read port (1-cycle registered read, holds when !rom_en)
//   rom_data              micro-word {end, loop, jmp, nxt, uop}
//   uop_valid/uop_ready   micro-op handshake; uop, uop_last, uop_idx
//   cur_ins               captured parent instruction
//   err                   one-cycle pulse on abort (null entry, wrap, runaway)
//
// state   | meaning
// MC_IDLE | waiting for an instruction, ROM idle
// MC_ISS  | rom_data holds the current micro-word, offering it downstream
module qupls_mc_sequencer
  import qupls_mc_sequencer_pkg::*;
#(
  parameter int AW      = MC_AW,
  parameter int UOPW    = MC_UOPW,
  parameter int LCW     = MC_LCW,
  parameter int MAXSTEP = MC_MAXSTEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  ex_instruction_t      ins,
  input  logic [AW-1:0]        mip,
  input  logic [LCW-1:0]       lpcnt,
  input  logic                 flush,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [UOPW+AW+2:0]   rom_data,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic [UOPW-1:0]      uop,
  output logic                 uop_last,
  output logic [5:0]           uop_idx,
  output ex_instruction_t      cur_ins,
  output logic                 err
);

  localparam int SW = $clog2(MAXSTEP + 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [SW-1:0] STEP_LAST = SW'(MAXSTEP - 1);

  mc_seq_state_t   state, state_n;
  logic [AW-1:0]   cur_addr;
  logic [LCW-1:0]  lc;
  logic [SW-1:0]   step;

  logic [AW-1:0]   w_nxt;
  logic            w_jmp, w_loop, w_end;
  logic [AW-1:0]   na_addr;
  logic [LCW-1:0]  na_lc;
  logic            na_wrap;

  logic            accept, advance, clear, abort;

  assign uop    = rom_data[UOPW-1:0];
  assign w_nxt  = rom_data[UOPW+AW-1:UOPW];
  assign w_jmp  = rom_data[UOPW+AW];
  assign w_loop = rom_data[UOPW+AW+1];
  assign w_end  = rom_data[UOPW+AW+2];

  qupls_mc_nextaddr #(.AW(AW), .LCW(LCW)) u_nextaddr (
    .cur    (cur_addr),
    .nxt    (w_nxt),
    .jmp    (w_jmp),
    .loop   (w_loop),
    .lc     (lc),
    .addr   (na_addr),
    .lc_nxt (na_lc),
    .wrap   (na_wrap)
  );

  always_comb begin
    state_n   = state;
    ins_ready = 1'b0;
    uop_valid = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = cur_addr;
    accept    = 1'b0;
    advance   = 1'b0;
    clear     = 1'b0;
    abort     = 1'b0;
    case (state)
      MC_IDLE: begin
        ins_ready = 1'b1;
        if (!flush && ins_valid) begin
          if (mip != '0) begin
            accept   = 1'b1;
            rom_en   = 1'b1;
            rom_addr = mip;
            state_n  = MC_ISS;
          end else begin
            // entry 0 means "no microcode": swallow the instruction and flag it
            abort = 1'b1;
          end
        end
      end
      MC_ISS: begin
        uop_valid = ~flush;
        if (flush) begin
          state_n = MC_IDLE;
          clear   = 1'b1;
        end else if (uop_ready) begin
          if (w_end) begin
            state_n = MC_IDLE;
            clear   = 1'b1;
          end else if (na_wrap || (step == STEP_LAST)) begin
            state_n = MC_IDLE;
            clear   = 1'b1;
            abort   = 1'b1;
          end else begin
            advance  = 1'b1;
            rom_en   = 1'b1;
            rom_addr = na_addr;
          end
        end
      end
      default: state_n = MC_IDLE;
    endcase
  end

  assign uop_last = uop_valid & w_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MC_IDLE;
      cur_addr <= '0;
      lc       <= '0;
      step     <= '0;
      uop_idx  <= '0;
      cur_ins  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      err   <= abort;
      if (accept) begin
        cur_ins  <= ins;
        cur_addr <= mip;
        lc       <= lpcnt;
        step     <= '0;
        uop_idx  <= '0;
      end
      if (advance) begin
        cur_addr <= na_addr;
        lc       <= na_lc;
        step     <= step + STEP_ONE;
        uop_idx  <= uop_idx + 6'd1;
      end
      if (clear) begin
        lc      <= '0;
        step    <= '0;
        uop_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qupls_mc_sequencer.sv
// Directed bench for the microcode sequencer with a behavioural ROM.
// Inputs are driven just after the falling edge, outputs sampled 1 ns later.
module tb_qupls_mc_sequencer;
  import qupls_mc_sequencer_pkg::*;

  localparam int AW = 12;
  localparam int UOPW = 32;
  localparam int LCW = 5;
  localparam int WW = UOPW + AW + 3;

  logic clk = 1'b0;
  logic rst_n;
  logic ins_valid, ins_ready;
  ex_instruction_t ins, cur_ins;
  logic [AW-1:0] mip, rom_addr;
  logic [LCW-1:0] lpcnt;
  logic flush, rom_en, uop_valid, uop_ready, uop_last, err;
  logic [WW-1:0] rom_data;
  logic [UOPW-1:0] uop;
  logic [5:0] uop_idx;

  logic [WW-1:0] mem [0:4095];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  qupls_mc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .mip(mip), .lpcnt(lpcnt), .flush(flush), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop(uop), .uop_last(uop_last), .uop_idx(uop_idx),
    .cur_ins(cur_ins), .err(err)
  );

  function automatic logic [UOPW-1:0] uval(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  function automatic logic [WW-1:0] mkw(input logic [AW-1:0] a, input logic [AW-1:0] nxt,
                                        input logic j, input logic l, input logic e);
    return {e, l, j, nxt, uval(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_uop(input string tag, input logic [AW-1:0] a, input int idx, input logic last);
    chk({tag, ".valid"}, 64'(uop_valid), 64'd1);
    chk({tag, ".uop"}, 64'(uop), 64'(uval(a)));
    chk({tag, ".idx"}, 64'(uop_idx), 64'(idx));
    chk({tag, ".last"}, 64'(uop_last), 64'(last));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ins_ready"}, 64'(ins_ready), 64'd1);
    chk({tag, ".rom_en"}, 64'(rom_en), 64'd0);
    chk({tag, ".rom_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, ".uop_valid"}, 64'(uop_valid), 64'd0);
    chk({tag, ".uop_last"}, 64'(uop_last), 64'd0);
    chk({tag, ".uop_idx"}, 64'(uop_idx), 64'd0);
    chk({tag, ".cur_ins"}, 64'(cur_ins), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
  endtask

  // offer an instruction in the current window; caller checks, next cycle drops it
  task automatic offer(input logic [AW-1:0] a, input logic [LCW-1:0] n, input logic [39:0] iv);
    ins_valid = 1'b1;
    mip = a;
    lpcnt = n;
    ins = iv;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h020] = mkw(12'h020, 12'h000, 1'b0, 1'b0, 1'b0);
    mem[12'h021] = mkw(12'h021, 12'h000, 1'b0, 1'b0, 1'b0);
    mem[12'h022] = mkw(12'h022, 12'h000, 1'b0, 1'b0, 1'b1);
    mem[12'h030] = mkw(12'h030, 12'h030, 1'b0, 1'b1, 1'b0);
    mem[12'h031] = mkw(12'h031, 12'h000, 1'b0, 1'b0, 1'b1);
    mem[12'h040] = mkw(12'h040, 12'h000, 1'b0, 1'b0, 1'b1);
    mem[12'h050] = mkw(12'h050, 12'h050, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) mem[12'h060 + i] = mkw(12'(12'h060 + i), 12'h000, 1'b0, 1'b0, 1'b0);
    mem[12'h064] = mkw(12'h064, 12'h000, 1'b0, 1'b0, 1'b1);
    mem[12'hFFF] = mkw(12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0);

    rom_data = '0;
    rst_n = 1'b0; ins_valid = 1'b0; ins = '0; mip = '0; lpcnt = '0;
    flush = 1'b0; uop_ready = 1'b1;

    // reset state
    cyc(); settle();
    chk_reset("rst");
    cyc(); rst_n = 1'b1; settle();
    chk_reset("rst_rel");

    // linear sequence 0x020..0x022
    cyc(); offer(12'h020, 5'd0, 40'h12_3456_789A); settle();
    chk("lin.acc_ready", 64'(ins_ready), 64'd1);
    chk("lin.acc_rom_en", 64'(rom_en), 64'd1);
    chk("lin.acc_rom_addr", 64'(rom_addr), 64'h020);
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("lin.u0", 12'h020, 0, 1'b0);
    chk("lin.u0_addr", 64'(rom_addr), 64'h021);
    chk("lin.u0_ins_ready", 64'(ins_ready), 64'd0);
    chk("lin.cur_ins", 64'(cur_ins), 64'h12_3456_789A);
    cyc(); settle();
    chk_uop("lin.u1", 12'h021, 1, 1'b0);
    chk("lin.u1_addr", 64'(rom_addr), 64'h022);
    cyc(); settle();
    chk_uop("lin.u2", 12'h022, 2, 1'b1);
    chk("lin.u2_rom_en", 64'(rom_en), 64'd0);
    chk("lin.u2_ins_ready", 64'(ins_ready), 64'd0);
    cyc(); settle();
    chk("lin.done_valid", 64'(uop_valid), 64'd0);
    chk("lin.done_ready", 64'(ins_ready), 64'd1);

    // counted loop: 4 uops from 0x030, then 0x031
    cyc(); offer(12'h030, 5'd3, 40'h00_0000_0030); settle();
    chk("loop.acc_addr", 64'(rom_addr), 64'h030);
    for (int i = 0; i < 5; i++) begin
      cyc(); ins_valid = 1'b0; settle();
      if (i < 4) begin
        chk_uop("loop.u", 12'h030, i, 1'b0);
        chk("loop.nxt", 64'(rom_addr), (i < 3) ? 64'h030 : 64'h031);
      end else begin
        chk_uop("loop.u", 12'h031, 4, 1'b1);
      end
    end
    cyc(); settle();
    chk("loop.done_valid", 64'(uop_valid), 64'd0);
    chk("loop.done_ready", 64'(ins_ready), 64'd1);

    // backpressure on second uop
    cyc(); offer(12'h020, 5'd0, 40'h00_0000_00BB); settle();
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("bp.u0", 12'h020, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); uop_ready = 1'b0; settle();
      chk_uop("bp.hold", 12'h021, 1, 1'b0);
      chk("bp.rom_en", 64'(rom_en), 64'd0);
      chk("bp.rom_addr", 64'(rom_addr), 64'h021);
    end
    cyc(); uop_ready = 1'b1; settle();
    chk_uop("bp.u1", 12'h021, 1, 1'b0);
    chk("bp.u1_rom_en", 64'(rom_en), 64'd1);
    chk("bp.u1_addr", 64'(rom_addr), 64'h022);
    cyc(); settle();
    chk_uop("bp.u2", 12'h022, 2, 1'b1);
    cyc(); settle();
    chk("bp.done_valid", 64'(uop_valid), 64'd0);

    // flush on second uop of 5-uop sequence, then new instruction at 0x040
    cyc(); offer(12'h060, 5'd0, 40'h00_0000_0060); settle();
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("fl.u0", 12'h060, 0, 1'b0);
    cyc(); flush = 1'b1; settle();
    chk("fl.valid", 64'(uop_valid), 64'd0);
    chk("fl.rom_en", 64'(rom_en), 64'd0);
    chk("fl.last", 64'(uop_last), 64'd0);
    cyc(); flush = 1'b0; offer(12'h040, 5'd0, 40'h00_0000_0040); settle();
    chk("fl.idle_ready", 64'(ins_ready), 64'd1);
    chk("fl.idle_valid", 64'(uop_valid), 64'd0);
    chk("fl.idle_err", 64'(err), 64'd0);
    chk("fl.acc_addr", 64'(rom_addr), 64'h040);
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("fl.new", 12'h040, 0, 1'b1);
    chk("fl.new_err", 64'(err), 64'd0);
    cyc(); settle();

    // null entry address
    cyc(); offer(12'h000, 5'd0, 40'h00_0000_0001); settle();
    chk("null.ready", 64'(ins_ready), 64'd1);
    chk("null.rom_en", 64'(rom_en), 64'd0);
    cyc(); ins_valid = 1'b0; settle();
    chk("null.err", 64'(err), 64'd1);
    chk("null.valid", 64'(uop_valid), 64'd0);
    cyc(); settle();
    chk("null.err_clr", 64'(err), 64'd0);
    chk("null.valid2", 64'(uop_valid), 64'd0);

    // runaway jump loop at 0x050
    cyc(); offer(12'h050, 5'd0, 40'h00_0000_0050); settle();
    for (int i = 0; i < 64; i++) begin
      cyc(); ins_valid = 1'b0; settle();
      chk("run.valid", 64'(uop_valid), 64'd1);
      chk("run.idx", 64'(uop_idx), 64'(i));
      chk("run.err", 64'(err), 64'd0);
    end
    chk("run.last_rom_en", 64'(rom_en), 64'd0);
    cyc(); settle();
    chk("run.abort_err", 64'(err), 64'd1);
    chk("run.abort_valid", 64'(uop_valid), 64'd0);
    chk("run.abort_ready", 64'(ins_ready), 64'd1);
    cyc(); settle();
    chk("run.err_clr", 64'(err), 64'd0);

    // address wrap at 0xFFF
    cyc(); offer(12'hFFF, 5'd0, 40'h00_0000_0FFF); settle();
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("wrap.u0", 12'hFFF, 0, 1'b0);
    chk("wrap.rom_en", 64'(rom_en), 64'd0);
    cyc(); settle();
    chk("wrap.err", 64'(err), 64'd1);
    chk("wrap.valid", 64'(uop_valid), 64'd0);
    chk("wrap.ready", 64'(ins_ready), 64'd1);
    cyc(); settle();
    chk("wrap.err_clr", 64'(err), 64'd0);

    // reset during third uop, then clean restart
    cyc(); offer(12'h060, 5'd0, 40'h00_0000_0066); settle();
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("mrst.u0", 12'h060, 0, 1'b0);
    cyc(); settle();
    chk_uop("mrst.u1", 12'h061, 1, 1'b0);
    cyc(); settle();
    chk_uop("mrst.u2", 12'h062, 2, 1'b0);
    rst_n = 1'b0; settle();
    chk_reset("mrst.async");
    cyc(); settle();
    chk_reset("mrst.held");
    cyc(); rst_n = 1'b1; offer(12'h020, 5'd0, 40'h00_0000_0077); settle();
    chk("mrst.acc_addr", 64'(rom_addr), 64'h020);
    cyc(); ins_valid = 1'b0; settle();
    chk_uop("mrst.r0", 12'h020, 0, 1'b0);
    chk("mrst.cur_ins", 64'(cur_ins), 64'h00_0000_0077);
    cyc(); settle();
    chk_uop("mrst.r1", 12'h021, 1, 1'b0);
    cyc(); settle();
    chk_uop("mrst.r2", 12'h022, 2, 1'b1);
    cyc(); settle();
    chk("mrst.done", 64'(ins_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
